// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath.
// Optional macro ILLEGAL_TRAP_EN: illegal instructions halt the core instead of retiring as NOPs.
module multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                Zero,
  input  logic                MemReady,
  output logic                PCWr,
  output logic                IRWr,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                RegDst,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic [ALU_OP_W-1:0] ALUOp,
  output logic [1:0]          NPCOp,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
  } state_t;

  // RTYPE is split per funct so later states never need the live funct field.
  typedef enum logic [3:0] {
    C_ILL, C_ADD, C_SUB, C_AND, C_OR, C_SLT,
    C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_J
  } cls_t;

  state_t               r_state, w_next;
  cls_t                 r_cls, w_cls;
  logic [CNT_W-1:0]     r_retired;
  logic                 r_illegal;
  logic                 w_pcwr, w_irwr, w_regwrite, w_memwrite;
  logic                 w_regdst, w_alusrc, w_memtoreg;
  logic [ALU_OP_W-1:0]  w_aluop;
  logic [1:0]           w_npcop;

  function automatic logic [ALU_OP_W-1:0] alu_of(input cls_t c);
    case (c)
      C_SUB, C_BEQ: alu_of = ALU_OP_W'(3'b001);
      C_AND:        alu_of = ALU_OP_W'(3'b010);
      C_OR, C_ORI:  alu_of = ALU_OP_W'(3'b011);
      C_SLT:        alu_of = ALU_OP_W'(3'b100);
      default:      alu_of = ALU_OP_W'(3'b000);
    endcase
  endfunction

  always_comb begin
    w_cls = C_ILL;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000: w_cls = C_ADD;
          6'b100010: w_cls = C_SUB;
          6'b100100: w_cls = C_AND;
          6'b100101: w_cls = C_OR;
          6'b101010: w_cls = C_SLT;
          default:   w_cls = C_ILL;
        endcase
      end
      6'b001000: w_cls = C_ADDI;
      6'b001101: w_cls = C_ORI;
      6'b100011: w_cls = C_LW;
      6'b101011: w_cls = C_SW;
      6'b000100: w_cls = C_BEQ;
      6'b000010: w_cls = C_J;
      default:   w_cls = C_ILL;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_pcwr     = 1'b0;
    w_irwr     = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_regdst   = 1'b0;
    w_alusrc   = 1'b0;
    w_memtoreg = 1'b0;
    w_aluop    = '0;
    w_npcop    = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_irwr = MemReady;
        if (MemReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_cls == C_J) begin
          w_pcwr  = 1'b1;
          w_npcop = 2'b10;
          w_next  = S_FETCH;
        end else if (w_cls == C_ILL) begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_HALT;
`else
          w_pcwr = 1'b1;
          w_next = S_FETCH;
`endif
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_aluop = alu_of(r_cls);
        case (r_cls)
          C_BEQ: begin
            w_pcwr  = 1'b1;
            w_npcop = Zero ? 2'b01 : 2'b00;
            w_next  = S_FETCH;
          end
          C_LW, C_SW: begin
            w_alusrc = 1'b1;
            w_next   = S_MEM;
          end
          C_ADDI, C_ORI: begin
            w_alusrc = 1'b1;
            w_next   = S_WB;
          end
          C_ADD, C_SUB, C_AND, C_OR, C_SLT: w_next = S_WB;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_alusrc = 1'b1;
        if (r_cls == C_SW) begin
          w_memwrite = 1'b1;
          if (MemReady) begin
            w_pcwr = 1'b1;
            w_next = S_FETCH;
          end
        end else if (MemReady) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_regwrite = 1'b1;
        w_pcwr     = 1'b1;
        w_next     = S_FETCH;
        w_aluop    = alu_of(r_cls);
        w_alusrc   = (r_cls == C_ADDI) || (r_cls == C_ORI) || (r_cls == C_LW);
        w_regdst   = (r_cls inside {C_ADD, C_SUB, C_AND, C_OR, C_SLT});
        w_memtoreg = (r_cls == C_LW);
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_cls     <= C_ILL;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_cls;
      if (w_pcwr) r_retired <= r_retired + 1'b1;
      if (r_state == S_DECODE && w_cls == C_ILL) r_illegal <= 1'b1;
    end
  end

  // Enables are gated by reset so nothing can write while rst is held low.
  assign PCWr     = w_pcwr     & rst;
  assign IRWr     = w_irwr     & rst;
  assign RegWrite = w_regwrite & rst;
  assign MemWrite = w_memwrite & rst;
  assign RegDst   = w_regdst;
  assign ALUSrc   = w_alusrc;
  assign MemtoReg = w_memtoreg;
  assign ALUOp    = w_aluop;
  assign NPCOp    = w_npcop;
  assign state    = r_state;
  assign retired  = r_retired;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: per-instruction expectations checked at each PCWr pulse.
module tb_multicycle_ctrl;
  localparam int CNT_W = 32;

  logic clk = 1'b0, rst = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic Zero = 1'b0, MemReady = 1'b0;
  logic PCWr, IRWr, RegWrite, MemWrite, RegDst, ALUSrc, MemtoReg;
  logic [2:0] ALUOp, state;
  logic [1:0] NPCOp;
  logic [CNT_W-1:0] retired;
  logic illegal;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CNT_W), .ALU_OP_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Zero(Zero),
    .MemReady(MemReady), .PCWr(PCWr), .IRWr(IRWr), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .ALUOp(ALUOp), .NPCOp(NPCOp), .state(state), .retired(retired), .illegal(illegal)
  );

  typedef struct {
    int         lat;
    logic [1:0] npc;
    logic [2:0] alu;
    logic       src, rd, m2r, mw, ill;
    int         mw_cnt, rw_cnt, ret;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int n_pass = 0, n_chk = 0;
  bit mon_en = 0;
  int cyc = 0, mw_c = 0, rw_c = 0, ir_c = 0;
  int n_ret = 0;
  bit ill_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: accumulates per-instruction activity and compares at every PCWr.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      cyc++;
      mw_c += int'(MemWrite);
      rw_c += int'(RegWrite);
      ir_c += int'(IRWr);
      if (PCWr) begin
        if (q.size() == 0) chk("unexpected_pcwr", 64'd1, 64'd0);
        else begin
          me = q.pop_front();
          chk("latency", 64'(cyc), 64'(me.lat));
          chk("npcop", 64'(NPCOp), 64'(me.npc));
          chk("aluop", 64'(ALUOp), 64'(me.alu));
          chk("alusrc", 64'(ALUSrc), 64'(me.src));
          chk("regdst", 64'(RegDst), 64'(me.rd));
          chk("memtoreg", 64'(MemtoReg), 64'(me.m2r));
          chk("memwrite", 64'(MemWrite), 64'(me.mw));
          chk("memwrite_cycles", 64'(mw_c), 64'(me.mw_cnt));
          chk("regwrite_cycles", 64'(rw_c), 64'(me.rw_cnt));
          chk("irwr_cycles", 64'(ir_c), 64'd1);
          chk("retired", 64'(retired), 64'(me.ret));
          chk("illegal", 64'(illegal), 64'(me.ill));
        end
        cyc = 0; mw_c = 0; rw_c = 0; ir_c = 0;
      end
    end
  end

  task automatic drv(input logic mr, input logic z, input logic [5:0] op, input logic [5:0] fn);
    MemReady = mr; Zero = z; opcode = op; funct = fn;
    @(posedge clk); #1;
  endtask

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h02};
  endfunction

  function automatic bit legal_fn(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  endfunction

  // k: 0-4 RTYPE add/sub/and/or/slt, 5 ADDI, 6 ORI, 7 LW, 8 SW, 9 BEQ, 10 J, 11 illegal
  task automatic run_instr(input int k);
    logic [5:0] rfn [5];
    logic [5:0] op, fn;
    int f, m;
    logic z;
    exp_t e;
    rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    f = int'($urandom_range(0, 2));
    m = (k == 7 || k == 8) ? int'($urandom_range(0, 3)) : 0;
    z = 1'($urandom);
    e = '{lat: 0, npc: 2'b00, alu: 3'b000, src: 1'b0, rd: 1'b0, m2r: 1'b0,
          mw: 1'b0, ill: ill_seen, mw_cnt: 0, rw_cnt: 0, ret: n_ret};
    op = 6'h00; fn = 6'h00;
    if (k <= 4) begin
      fn = rfn[k]; e.lat = f + 4; e.rw_cnt = 1; e.rd = 1'b1; e.alu = 3'(k);
    end else begin
      case (k)
        5:  begin op = 6'h08; e.lat = f + 4; e.rw_cnt = 1; e.src = 1'b1; end
        6:  begin op = 6'h0d; e.lat = f + 4; e.rw_cnt = 1; e.src = 1'b1; e.alu = 3'b011; end
        7:  begin op = 6'h23; e.lat = f + 5 + m; e.rw_cnt = 1; e.src = 1'b1; e.m2r = 1'b1; end
        8:  begin op = 6'h2b; e.lat = f + 4 + m; e.src = 1'b1; e.mw = 1'b1; e.mw_cnt = m + 1; end
        9:  begin op = 6'h04; e.lat = f + 3; e.alu = 3'b001; e.npc = z ? 2'b01 : 2'b00; end
        10: begin op = 6'h02; e.lat = f + 2; e.npc = 2'b10; end
        default: begin
          e.lat = f + 2;
          if ($urandom % 2 == 0) begin
            op = 6'h00;
            do fn = 6'($urandom); while (legal_fn(fn));
          end else begin
            do op = 6'($urandom); while (legal_op(op));
          end
        end
      endcase
    end
    q.push_back(e);
    n_ret++;
    if (k == 11) ill_seen = 1;
    // Opcode/funct are only meaningful in DECODE; elsewhere they carry noise.
    repeat (f) drv(1'b0, 1'($urandom), 6'($urandom), 6'($urandom));
    drv(1'b1, 1'($urandom), 6'($urandom), 6'($urandom));
    drv(1'($urandom), 1'($urandom), op, fn);
    if (k != 10 && k != 11) drv(1'($urandom), z, 6'($urandom), 6'($urandom));
    if (k == 7 || k == 8) begin
      repeat (m) drv(1'b0, 1'($urandom), 6'($urandom), 6'($urandom));
      drv(1'b1, 1'($urandom), 6'($urandom), 6'($urandom));
    end
    if (k <= 7) drv(1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom));
  endtask

  initial begin
    int kmax;
    int pc_sum;
    bit hit;
`ifdef ILLEGAL_TRAP_EN
    kmax = 10;
`else
    kmax = 11;
`endif
    MemReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_irwr", 64'(IRWr), 64'd0);
    chk("rst_pcwr", 64'(PCWr), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1;
    for (int i = 0; i < 200; i++) run_instr(int'($urandom_range(0, kmax)));
    mon_en = 0;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    // Abort an add in WB with reset; the write must disappear immediately.
    opcode = 6'h00; funct = 6'h20; MemReady = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (state == 3'd4) hit = 1;
    end
    chk("reach_wb", 64'(hit), 64'd1);
    chk("wb_regwrite", 64'(RegWrite), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_state", 64'(state), 64'd0);
    chk("abort_regwrite", 64'(RegWrite), 64'd0);
    chk("abort_pcwr", 64'(PCWr), 64'd0);
    chk("abort_retired", 64'(retired), 64'd0);
    chk("abort_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    chk("held_irwr", 64'(IRWr), 64'd0);

    // Release straight into an illegal opcode.
    @(posedge clk); #1;
    rst = 1'b1; opcode = 6'h3f; funct = 6'h00; MemReady = 1'b1;
    @(negedge clk);
    chk("rel_irwr", 64'(IRWr), 64'd1);
    chk("rel_state", 64'(state), 64'd0);
    @(negedge clk);
    chk("ill_decode", 64'(state), 64'd1);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_dec_pcwr", 64'(PCWr), 64'd0);
    @(negedge clk);
    chk("ill_flag", 64'(illegal), 64'd1);
    chk("halt_state", 64'(state), 64'd5);
    pc_sum = 0;
    repeat (5) begin
      @(negedge clk);
      pc_sum += int'(PCWr) + int'(IRWr) + int'(RegWrite) + int'(MemWrite);
    end
    chk("halt_no_enables", 64'(pc_sum), 64'd0);
    chk("halt_stays", 64'(state), 64'd5);
    chk("halt_retired", 64'(retired), 64'd0);
`else
    chk("ill_dec_pcwr", 64'(PCWr), 64'd1);
    chk("ill_dec_npc", 64'(NPCOp), 64'd0);
    @(negedge clk);
    chk("ill_flag", 64'(illegal), 64'd1);
    chk("nop_state", 64'(state), 64'd0);
    chk("nop_retired", 64'(retired), 64'd1);
    pc_sum = 0;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
